// File: rtl/multi_cycle_controller_if.sv
// multi_cycle_controller_if
//   Bundles the instruction fields, datapath status and memory handshake
//   flowing into the multi-cycle controller, together with every datapath
//   control strobe it drives back out.
//   master : controller side (takes the fields and status, drives the controls)
//   slave  : datapath / memory side
interface multi_cycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       slt_out;
  logic       mem_ready;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] imm_src;
  logic [2:0] alu_control;
  logic       inst_done;
  logic       illegal_op;

  modport master (
    input  op, funct3, funct7b5, zero, slt_out, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, inst_done, illegal_op
  );

  modport slave (
    output op, funct3, funct7b5, zero, slt_out, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, inst_done, illegal_op
  );
endinterface

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller
//   Moore-style control FSM for a multi-cycle RV32I subset
//   (lw, sw, R-type, I-type ALU, beq/bne/blt/bge, jal, jalr, lui).
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset, returns the FSM to FETCH
//     bus  - multi_cycle_controller_if.master: instruction fields, zero /
//            slt_out status, mem_ready handshake in; datapath controls,
//            inst_done and illegal_op pulses out
module multi_cycle_controller (
  input logic                      clk,
  input logic                      rst,
  multi_cycle_controller_if.master bus
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_LUI
  } state_t;

  state_t r_state, w_next;
  logic   w_legal;

  // R/I funct3 -> ALU op; SUB only when the caller allows funct7b5 to count.
  function automatic logic [2:0] f_alu(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  f_alu = sub ? ALU_SUB : ALU_ADD;
      3'b111:  f_alu = ALU_AND;
      3'b110:  f_alu = ALU_OR;
      3'b100:  f_alu = ALU_XOR;
      3'b010:  f_alu = ALU_SLT;
      default: f_alu = ALU_ADD;
    endcase
  endfunction

  // Opcode + funct3 legality, evaluated in DECODE so that a bad instruction
  // never reaches a state with write enables.
  always_comb begin
    w_legal = 1'b0;
    case (bus.op)
      OP_R, OP_I: w_legal = (bus.funct3 inside {3'b000, 3'b111, 3'b110, 3'b100, 3'b010});
      OP_BR:      w_legal = (bus.funct3 inside {3'b000, 3'b001, 3'b100, 3'b101});
      OP_LW,
      OP_SW:      w_legal = (bus.funct3 == 3'b010);
      OP_JALR:    w_legal = (bus.funct3 == 3'b000);
      OP_JAL,
      OP_LUI:     w_legal = 1'b1;
      default:    w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:     if (bus.mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        w_next = S_FETCH;
        if (w_legal) begin
          case (bus.op)
            OP_LW, OP_SW: w_next = S_MEM_ADR;
            OP_R:         w_next = S_EXEC_R;
            OP_I:         w_next = S_EXEC_I;
            OP_BR:        w_next = S_BRANCH;
            OP_JAL:       w_next = S_JAL;
            OP_JALR:      w_next = S_JALR;
            OP_LUI:       w_next = S_LUI;
            default:      w_next = S_FETCH;
          endcase
        end
      end
      S_MEM_ADR:   w_next = (bus.op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (bus.mem_ready) w_next = S_MEM_WB;
      S_MEM_WRITE: if (bus.mem_ready) w_next = S_FETCH;
      S_EXEC_R,
      S_EXEC_I,
      S_JAL:       w_next = S_ALU_WB;
      S_JALR:      w_next = S_JAL;
      default:     w_next = S_FETCH;
    endcase
  end

  logic       w_pc_write, w_adr_src, w_mem_write, w_ir_write, w_reg_write;
  logic       w_inst_done, w_illegal_op;
  logic [1:0] w_result_src, w_alu_src_a, w_alu_src_b;
  logic [2:0] w_imm_src, w_alu_control;

  always_comb begin
    w_pc_write    = 1'b0;
    w_adr_src     = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_inst_done   = 1'b0;
    w_illegal_op  = 1'b0;
    w_result_src  = 2'b00;
    w_alu_src_a   = 2'b00;
    w_alu_src_b   = 2'b00;
    w_imm_src     = IMM_I;
    w_alu_control = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = bus.mem_ready;
        w_pc_write   = bus.mem_ready;
      end
      S_DECODE: begin
        w_alu_src_a  = 2'b01;
        w_alu_src_b  = 2'b01;
        w_imm_src    = (bus.op == OP_JAL) ? IMM_J : IMM_B;
        w_illegal_op = ~w_legal;
      end
      S_MEM_ADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_imm_src   = (bus.op == OP_SW) ? IMM_S : IMM_I;
      end
      S_MEM_READ:  w_adr_src = 1'b1;
      S_MEM_WB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_inst_done  = 1'b1;
      end
      S_MEM_WRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        w_inst_done = bus.mem_ready;
      end
      S_EXEC_R: begin
        w_alu_src_a   = 2'b10;
        w_alu_control = f_alu(bus.funct3, bus.funct7b5);
      end
      S_EXEC_I: begin
        w_alu_src_a   = 2'b10;
        w_alu_src_b   = 2'b01;
        w_alu_control = f_alu(bus.funct3, 1'b0);
      end
      S_ALU_WB: begin
        w_reg_write = 1'b1;
        w_inst_done = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a = 2'b10;
        w_inst_done = 1'b1;
        case (bus.funct3)
          3'b000:  begin w_alu_control = ALU_SUB; w_pc_write =  bus.zero;    end
          3'b001:  begin w_alu_control = ALU_SUB; w_pc_write = ~bus.zero;    end
          3'b100:  begin w_alu_control = ALU_SLT; w_pc_write =  bus.slt_out; end
          3'b101:  begin w_alu_control = ALU_SLT; w_pc_write = ~bus.slt_out; end
          default: w_pc_write = 1'b0;
        endcase
      end
      S_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_write  = 1'b1;
      end
      S_JALR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
      end
      S_LUI: begin
        w_imm_src    = IMM_U;
        w_result_src = 2'b11;
        w_reg_write  = 1'b1;
        w_inst_done  = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are masked by rst directly: FETCH with mem_ready=1 would
  // otherwise assert pc_write/ir_write while reset is held.
  assign bus.pc_write    = w_pc_write   & ~rst;
  assign bus.ir_write    = w_ir_write   & ~rst;
  assign bus.mem_write   = w_mem_write  & ~rst;
  assign bus.reg_write   = w_reg_write  & ~rst;
  assign bus.inst_done   = w_inst_done  & ~rst;
  assign bus.illegal_op  = w_illegal_op & ~rst;
  assign bus.adr_src     = w_adr_src;
  assign bus.result_src  = w_result_src;
  assign bus.alu_src_a   = w_alu_src_a;
  assign bus.alu_src_b   = w_alu_src_b;
  assign bus.imm_src     = w_imm_src;
  assign bus.alu_control = w_alu_control;

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 Parameters: none; all encodings below SHALL be fixed.
REQ-002 clk  input  1  rising-edge system clock, the only clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 op  input  7  instruction opcode field, from the instruction register.
REQ-005 funct3  input  3  instruction funct3 field.
REQ-006 funct7b5  input  1  instruction bit 30.
REQ-007 zero  input  1  ALU result == 0.
REQ-008 slt_out  input  1  ALU result bit 0.
REQ-009 mem_ready  input  1  unified memory completes the current access this cycle.
REQ-010 pc_write  output  1  PC load enable.
REQ-011 adr_src  output  1  memory address select: 0 = PC, 1 = result bus.
REQ-012 mem_write  output  1  data memory write strobe.
REQ-013 ir_write  output  1  instruction register and old-PC load enable.
REQ-014 reg_write  output  1  register file write enable.
REQ-015 result_src  output  2  result bus select: 00 = ALUOut reg, 01 = mem data reg, 10 = ALU direct, 11 = immediate.
REQ-016 alu_src_a  output  2  ALU A select: 00 = PC, 01 = old PC, 10 = A reg.
REQ-017 alu_src_b  output  2  ALU B select: 00 = B reg, 01 = immediate, 10 = constant 4.
REQ-018 imm_src  output  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
REQ-019 alu_control  output  3  ALU operation: 000 = ADD, 001 = SUB, 010 = AND, 011 = OR, 100 = XOR, 101 = SLT.
REQ-020 inst_done  output  1  one-cycle pulse in the final cycle of each legal instruction.
REQ-021 illegal_op  output  1  one-cycle pulse in DECODE when the opcode or funct3 is unsupported.

Function
REQ-022 Moore FSM states: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, JALR, LUI. Outputs are decoded from the state, plus the op, funct3 and mem_ready qualifiers listed.
REQ-023 Unlisted outputs SHALL be 0 in every state; alu_control defaults to ADD.
REQ-024 FETCH: adr_src=0; alu_src_a=00, alu_src_b=10, ADD; result_src=10.
  - ir_write=pc_write=mem_ready.
  - Stay in FETCH while mem_ready=0; otherwise go to DECODE.
REQ-025 DECODE: alu_src_a=01, alu_src_b=01, ADD; imm_src=J if op=1101111, else B.
  - Next state by op: 0000011/0100011 -> MEM_ADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI.
  - Any other op: illegal_op=1, next FETCH.
REQ-026 MEM_ADR: alu_src_a=10, alu_src_b=01, ADD; imm_src=S for sw, I for lw; next MEM_WRITE for sw, MEM_READ for lw.
REQ-027 MEM_READ: adr_src=1, result_src=00; hold while mem_ready=0; then MEM_WB.
REQ-028 MEM_WB: result_src=01, reg_write=1, inst_done=1; next FETCH.
REQ-029 MEM_WRITE: adr_src=1, result_src=00.
  - mem_write=1 on every cycle in this state, held until mem_ready=1.
  - On mem_ready=1: inst_done=1, next FETCH.
REQ-030 EXEC_R: alu_src_a=10, alu_src_b=00; next ALU_WB.
  - funct3 mapping: 000 -> ADD, or SUB if funct7b5=1; 111 -> AND; 110 -> OR; 100 -> XOR; 010 -> SLT.
REQ-031 EXEC_I: alu_src_a=10, alu_src_b=01, imm_src=I; same mapping as EXEC_R but funct7b5 ignored (000 is always ADD); next ALU_WB.
REQ-032 Unsupported funct3 for R, I, branch, lw (not 010), sw (not 010) or jalr (not 000) SHALL be detected in DECODE: illegal_op=1, next FETCH, no write enables.
REQ-033 ALU_WB: result_src=00, reg_write=1, inst_done=1; next FETCH.
REQ-034 BRANCH: alu_src_a=10, alu_src_b=00, result_src=00; inst_done=1; next FETCH.
  - funct3 000 (beq): SUB, pc_write=zero.
  - 001 (bne): SUB, pc_write=~zero.
  - 100 (blt): SLT, pc_write=slt_out.
  - 101 (bge): SLT, pc_write=~slt_out.
REQ-035 JAL: alu_src_a=01, alu_src_b=10, ADD; result_src=00, pc_write=1; next ALU_WB.
REQ-036 JALR: alu_src_a=10, alu_src_b=01, imm_src=I, ADD; next JAL.
REQ-037 LUI: imm_src=U, result_src=11, reg_write=1, inst_done=1; next FETCH.
REQ-038 Latency with mem_ready tied to 1, in cycles: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui 3, illegal 2.
REQ-039 Each added mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE SHALL add exactly one cycle.
REQ-040 At most one of inst_done and illegal_op SHALL be high in any cycle.

Reset
REQ-041 rst=1 SHALL force state to FETCH immediately, without waiting for a clock edge.
REQ-042 While rst=1, pc_write, ir_write, mem_write, reg_write, inst_done and illegal_op SHALL be 0.
REQ-043 Reset asserted in any state, including mid-stall, SHALL abort the instruction with no further write enable.
REQ-044 First FETCH behaviour begins on the first rising edge after rst deasserts.

Verification
REQ-045 add (op=0110011, funct3=000, funct7b5=0), mem_ready=1 -> FETCH, DECODE, EXEC_R, ALU_WB; alu_control=000; reg_write and inst_done only in cycle 4.
REQ-046 lw (op=0000011, funct3=010) with mem_ready=0 for 2 cycles in MEM_READ -> 7 cycles total; reg_write=1 with result_src=01 only in the last cycle.
REQ-047 bne (funct3=001) with zero=0 -> pc_write=1 in BRANCH; repeat with zero=1 -> pc_write=0; both take 3 cycles.
REQ-048 jalr (op=1100111, funct3=000) -> JALR with A=10/B=01, then JAL with pc_write=1 and result_src=00, then ALU_WB with reg_write=1; 5 cycles.
REQ-049 op=1111111 -> illegal_op pulse in DECODE, back to FETCH, no reg_write or mem_write.
REQ-050 rst asserted mid-cycle during MEM_WRITE with mem_ready=0 -> mem_write drops to 0 before the next clock edge; state is FETCH after release.
